prim_shadow_wr_ctrl: RTL and testbench
======================================

Name: prim_shadow_wr_ctrl

Overview:
- Two-phase write controller for one shadowed register. Sits directly upstream of the enabled committed-value flop (Width bits, async reset).
- Drives that flop's enable and data, and reads its q back.
- Holds the staged copy and an inverted shadow copy internally. Flags update mismatches and storage corruption for the alert logic.

Parameters:
- Width, 8, data width of staged, shadow and committed values.
- ResetValue, 0, committed reset value; the internal shadow resets to ~ResetValue.
- TimeoutCycles, 16, max cycles in the STAGED phase; used only with the optional feature. Must be >= 1.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- we_i  in  1  software write strobe, single-cycle.
- wd_i  in  Width  software write data.
- de_i  in  1  hardware direct-update strobe.
- d_i  in  Width  hardware update data.
- committed_q_i  in  Width  q of the downstream committed flop.
- commit_en_o  out  1  enable to the committed flop.
- commit_d_o  out  Width  data to the committed flop.
- staged_q_o  out  Width  staged value.
- phase_o  out  1  0 = IDLE, 1 = STAGED.
- update_err_o  out  1  single-cycle pulse on a second-write mismatch.
- storage_err_o  out  1  sticky; set when committed_q_i != ~shadow.
- de_drop_o  out  1  single-cycle pulse when de_i is dropped.

Behaviour:
- Reset (rst_i=1, asynchronous):
  - phase = IDLE; staged = 0; shadow = ~ResetValue.
  - storage_err_o = 0; all pulses 0; commit_en_o = 0.
- IDLE + we_i:
  - staged <= wd_i; next phase STAGED.
  - No commit.
- STAGED + we_i with wd_i == staged:
  - commit_en_o = 1 combinationally in the same cycle; commit_d_o = wd_i.
  - shadow <= ~wd_i; next phase IDLE.
  - The committed flop updates on the same edge, so the new value is visible 1 cycle after the second write.
- STAGED + we_i with wd_i != staged:
  - No commit; update_err_o pulses that cycle; next phase IDLE.
  - staged keeps its old value.
- de_i with no we_i, in either phase:
  - commit_en_o = 1; commit_d_o = d_i; shadow <= ~d_i.
  - staged <= d_i; phase unchanged.
- de_i and we_i in the same cycle:
  - The software write path wins; the hardware update is discarded.
  - de_drop_o pulses for that cycle.
- commit_en_o = 0 in every other case. commit_d_o = staged when commit_en_o = 0 (a don't-care value, but it must be fixed).
- Storage check:
  - Evaluated every cycle outside reset: storage_err_o <= 1 if committed_q_i != ~shadow.
  - Suppressed in the cycle commit_en_o = 1 and in the first cycle after reset deassertion.
  - Cleared only by rst_i.
- Reset mid-STAGED: returns to IDLE and discards staged. The committed flop reset is owned downstream.
- phase_o is registered. All pulse outputs are combinational from the registered state and current inputs.

Optional Feature:
- Macro: PRIM_SHADOW_STAGE_TIMEOUT_EN.
- When defined:
  - A $clog2(TimeoutCycles+1)-bit counter clears on entry to STAGED and increments each cycle in STAGED without we_i.
  - When the counter reaches TimeoutCycles, next phase is IDLE, staged is kept, and timeout_o pulses 1 cycle.
  - An extra port timeout_o (out, 1) exists.
- When undefined:
  - No counter and no timeout_o port.
  - STAGED persists indefinitely until the next we_i or rst_i.

Test Plan:
- Width=8: reset released, we_i with 0x5A, then we_i with 0x5A two cycles later -> phase 0→1→0; commit_en_o=1 only on the second write; committed_q_i=0x5A next cycle; shadow=0xA5; storage_err_o=0.
- we_i 0x5A then we_i 0x3C -> update_err_o=1 for one cycle; commit_en_o stays 0; phase=0; staged_q_o=0x5A.
- In STAGED, de_i=1 with d_i=0x77 -> commit_en_o=1, commit_d_o=0x77, staged_q_o=0x77, phase stays 1.
- de_i=1 (d_i=0x11) together with first-phase we_i (wd_i=0x22) -> de_drop_o=1; staged_q_o=0x22; commit_en_o=0.
- Force committed_q_i=0x01 while shadow=0xFF (committed 0x00) -> storage_err_o=1 next cycle and stays 1 until rst_i pulses.
- With PRIM_SHADOW_STAGE_TIMEOUT_EN and TimeoutCycles=4: first write, then idle -> timeout_o pulses 4 cycles after entry to STAGED; phase=0; a following single we_i only re-stages, no commit.

Source files
------------

// File: rtl/prim_shadow_wr_ctrl.sv
// Two-phase write controller for one shadowed register: stages, confirms and commits writes,
// keeps an inverted shadow copy and flags mismatches. Optional: PRIM_SHADOW_STAGE_TIMEOUT_EN.
module prim_shadow_wr_ctrl #(
   parameter int unsigned      Width         = 8,
   parameter logic [Width-1:0] ResetValue    = '0,
   parameter int unsigned      TimeoutCycles = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             we_i,
   input  logic [Width-1:0] wd_i,
   input  logic             de_i,
   input  logic [Width-1:0] d_i,
   input  logic [Width-1:0] committed_q_i,
   output logic             commit_en_o,
   output logic [Width-1:0] commit_d_o,
   output logic [Width-1:0] staged_q_o,
   output logic             phase_o,
   output logic             update_err_o,
   output logic             storage_err_o,
`ifdef PRIM_SHADOW_STAGE_TIMEOUT_EN
   output logic             timeout_o,
`endif
   output logic             de_drop_o
);

   typedef enum logic {StIdle, StStaged} phase_e;

   phase_e           r_phase, w_phase_d;
   logic [Width-1:0] r_staged, w_staged_d;
   logic [Width-1:0] r_shadow, w_shadow_d;
   logic             r_storage_err;
   logic             r_post_rst;
   logic             w_commit_en;
   logic [Width-1:0] w_commit_d;
   logic             w_update_err;
   logic             w_de_drop;
   logic             w_storage_bad;

`ifdef PRIM_SHADOW_STAGE_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(TimeoutCycles + 1);
   logic [CntW-1:0] r_cnt, w_cnt_d;
   logic            w_timeout;
`endif

   always_comb begin
      w_phase_d    = r_phase;
      w_staged_d   = r_staged;
      w_shadow_d   = r_shadow;
      w_commit_en  = 1'b0;
      w_commit_d   = r_staged;
      w_update_err = 1'b0;
      w_de_drop    = 1'b0;
      if (we_i) begin
         // Software write wins; a concurrent hardware update is discarded.
         w_de_drop = de_i;
         unique case (r_phase)
            StIdle: begin
               w_staged_d = wd_i;
               w_phase_d  = StStaged;
            end
            StStaged: begin
               w_phase_d = StIdle;
               if (wd_i == r_staged) begin
                  w_commit_en = 1'b1;
                  w_commit_d  = wd_i;
                  w_shadow_d  = ~wd_i;
               end else begin
                  w_update_err = 1'b1;
               end
            end
         endcase
      end else if (de_i) begin
         w_commit_en = 1'b1;
         w_commit_d  = d_i;
         w_shadow_d  = ~d_i;
         w_staged_d  = d_i;
      end
`ifdef PRIM_SHADOW_STAGE_TIMEOUT_EN
      w_timeout = (r_phase == StStaged) && !we_i && (r_cnt == CntW'(TimeoutCycles));
      w_cnt_d   = r_cnt;
      if (r_phase == StIdle) begin
         w_cnt_d = '0;
      end else if (!we_i && !w_timeout) begin
         w_cnt_d = r_cnt + 1'b1;
      end
      if (w_timeout) begin
         w_phase_d = StIdle;
      end
`endif
   end

   assign w_storage_bad = (committed_q_i != ~r_shadow);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_phase       <= StIdle;
         r_staged      <= '0;
         r_shadow      <= ~ResetValue;
         r_storage_err <= 1'b0;
         r_post_rst    <= 1'b1;
      end else begin
         r_phase    <= w_phase_d;
         r_staged   <= w_staged_d;
         r_shadow   <= w_shadow_d;
         r_post_rst <= 1'b0;
         // The committed flop is in flux on a commit edge, and its reset may lag ours by a cycle.
         if (!r_post_rst && !w_commit_en && w_storage_bad) begin
            r_storage_err <= 1'b1;
         end
      end
   end

`ifdef PRIM_SHADOW_STAGE_TIMEOUT_EN
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= w_cnt_d;
      end
   end

   assign timeout_o = w_timeout;
`endif

   assign commit_en_o   = w_commit_en;
   assign commit_d_o    = w_commit_d;
   assign staged_q_o    = r_staged;
   assign phase_o       = (r_phase == StStaged);
   assign update_err_o  = w_update_err;
   assign storage_err_o = r_storage_err;
   assign de_drop_o     = w_de_drop;

endmodule

// File: tb/tb_prim_shadow_wr_ctrl.sv
// Self-checking bench for prim_shadow_wr_ctrl: directed plan plus randomized traffic
// compared every cycle against a rule-level model of the shadowed register.
module tb_prim_shadow_wr_ctrl;

   localparam int unsigned Width    = 8;
   localparam logic [7:0]  ResetVal = 8'h00;
   localparam int unsigned Tmo      = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       we  = 1'b0;
   logic [7:0] wd  = '0;
   logic       de  = 1'b0;
   logic [7:0] d   = '0;
   logic [7:0] flip = '0;
   logic [7:0] env_q;
   logic [7:0] comm_q;
   logic       commit_en;
   logic [7:0] commit_d;
   logic [7:0] staged_q;
   logic       phase;
   logic       update_err;
   logic       storage_err;
   logic       de_drop;
`ifdef PRIM_SHADOW_STAGE_TIMEOUT_EN
   logic       timeout;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   prim_shadow_wr_ctrl #(
      .Width         (Width),
      .ResetValue    (ResetVal),
      .TimeoutCycles (Tmo)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .we_i          (we),
      .wd_i          (wd),
      .de_i          (de),
      .d_i           (d),
      .committed_q_i (comm_q),
      .commit_en_o   (commit_en),
      .commit_d_o    (commit_d),
      .staged_q_o    (staged_q),
      .phase_o       (phase),
      .update_err_o  (update_err),
      .storage_err_o (storage_err),
`ifdef PRIM_SHADOW_STAGE_TIMEOUT_EN
      .timeout_o     (timeout),
`endif
      .de_drop_o     (de_drop)
   );

   // Downstream committed flop, with an injectable bit-flip on its q.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) env_q <= ResetVal;
      else if (commit_en) env_q <= commit_d;
   end
   assign comm_q = env_q ^ flip;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Reference model: the register's abstract contents and pending software write.
   bit       m_staged_valid;
   bit [7:0] m_staged, m_shadow, m_comm;
   bit       m_err, m_first;
   int       m_wait;

   always @(negedge clk) begin
      bit       e_commit, e_uerr, e_drop, e_tmo;
      bit [7:0] e_d;
      if (rst) begin
         m_staged_valid = 0; m_staged = 0; m_shadow = ~ResetVal; m_comm = ResetVal;
         m_err = 0; m_first = 1; m_wait = 0;
         check("rst_phase", phase, 0);
         check("rst_staged", staged_q, 0);
         check("rst_serr", storage_err, 0);
         check("rst_commit", commit_en, 0);
      end else begin
         e_commit = 0; e_uerr = 0; e_drop = 0; e_tmo = 0; e_d = m_staged;
         check("phase", phase, 32'(m_staged_valid));
         check("staged", staged_q, m_staged);
         check("storage_err", storage_err, 32'(m_err));
         check("committed", env_q, m_comm);
         // Storage check uses the value the DUT sees before this edge.
         if (!m_first && !(!we && de) && !(we && m_staged_valid && wd == m_staged)
             && ((m_comm ^ flip) != ~m_shadow)) m_err = 1;
         if (we) begin
            e_drop = de;
            if (!m_staged_valid) begin
               m_staged = wd; m_staged_valid = 1; m_wait = 0;
            end else begin
               m_staged_valid = 0;
               if (wd == m_staged) begin
                  e_commit = 1; e_d = wd; m_shadow = ~wd; m_comm = wd;
               end else begin
                  e_uerr = 1;
               end
            end
         end else begin
`ifdef PRIM_SHADOW_STAGE_TIMEOUT_EN
            if (m_staged_valid) begin
               if (m_wait == Tmo) begin
                  e_tmo = 1; m_staged_valid = 0;
               end else begin
                  m_wait++;
               end
            end
`endif
            if (de) begin
               e_commit = 1; e_d = d; m_shadow = ~d; m_staged = d; m_comm = d;
            end
         end
         check("commit_en", commit_en, 32'(e_commit));
         check("commit_d", commit_d, e_d);
         check("update_err", update_err, 32'(e_uerr));
         check("de_drop", de_drop, 32'(e_drop));
`ifdef PRIM_SHADOW_STAGE_TIMEOUT_EN
         check("timeout", timeout, 32'(e_tmo));
`endif
         m_first = 0;
      end
   end

   task automatic drive(input bit w, input bit [7:0] wv, input bit h, input bit [7:0] hv,
                        input bit [7:0] f = 8'h00);
      @(posedge clk);
      #1;
      we = w; wd = wv; de = h; d = hv; flip = f;
      #1;
   endtask

   task automatic idle();
      drive(0, 8'h00, 0, 8'h00);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst = 1; we = 0; de = 0; flip = '0;
      #1;
      check("lit_rst_phase", phase, 0);
      check("lit_rst_serr", storage_err, 0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 0;
   endtask

   initial begin
      do_reset();
      // Matching double write commits on the second write.
      drive(1, 8'h5A, 0, 8'h00);
      check("lit_w1_phase", phase, 0);
      check("lit_w1_commit", commit_en, 0);
      idle();
      check("lit_w1_staged_phase", phase, 1);
      check("lit_w1_staged", staged_q, 8'h5A);
      drive(1, 8'h5A, 0, 8'h00);
      check("lit_w2_commit", commit_en, 1);
      check("lit_w2_d", commit_d, 8'h5A);
      idle();
      check("lit_w2_q", env_q, 8'h5A);
      check("lit_w2_phase", phase, 0);
      check("lit_w2_serr", storage_err, 0);
      // Mismatched second write.
      drive(1, 8'h5A, 0, 8'h00);
      drive(1, 8'h3C, 0, 8'h00);
      check("lit_mm_uerr", update_err, 1);
      check("lit_mm_commit", commit_en, 0);
      idle();
      check("lit_mm_uerr_gone", update_err, 0);
      check("lit_mm_phase", phase, 0);
      check("lit_mm_staged", staged_q, 8'h5A);
      // Hardware update while staged.
      drive(1, 8'h10, 0, 8'h00);
      drive(0, 8'h00, 1, 8'h77);
      check("lit_de_commit", commit_en, 1);
      check("lit_de_d", commit_d, 8'h77);
      idle();
      check("lit_de_staged", staged_q, 8'h77);
      check("lit_de_phase", phase, 1);
      drive(1, 8'h77, 0, 8'h00);
      idle();
      // Collision: software write wins.
      drive(1, 8'h22, 1, 8'h11);
      check("lit_drop", de_drop, 1);
      check("lit_drop_commit", commit_en, 0);
      idle();
      check("lit_drop_staged", staged_q, 8'h22);
      drive(1, 8'h22, 0, 8'h00);
      idle();
      // Storage corruption is sticky until reset.
      do_reset();
      idle();
      drive(0, 8'h00, 0, 8'h00, 8'h01);
      check("lit_corrupt_pre", storage_err, 0);
      idle();
      check("lit_corrupt_set", storage_err, 1);
      repeat (3) idle();
      check("lit_corrupt_sticky", storage_err, 1);
      do_reset();
      idle();
      check("lit_corrupt_clr", storage_err, 0);
`ifdef PRIM_SHADOW_STAGE_TIMEOUT_EN
      drive(1, 8'h44, 0, 8'h00);
      repeat (4) idle();
      idle();
      check("lit_tmo_pulse", timeout, 1);
      idle();
      check("lit_tmo_phase", phase, 0);
      drive(1, 8'h44, 0, 8'h00);
      check("lit_tmo_restage", commit_en, 0);
      idle();
`endif
      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         bit       w, h;
         bit [7:0] wv, hv, f;
         w  = ($urandom_range(0, 2) == 0);
         wv = (m_staged_valid && $urandom_range(0, 1) == 0) ? m_staged : 8'($urandom);
         h  = ($urandom_range(0, 3) == 0);
         hv = 8'($urandom);
         f  = ($urandom_range(0, 150) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
         if (i % 400 == 399) do_reset();
         else drive(w, wv, h, hv, f);
      end
      idle();
      @(negedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
